// File: rtl/mbist_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module   : mbist_seq_gen
//  Purpose  : March C- sequence generator and read-data checker for the MBIST
//             controller. Tracks the element/op/address/background position,
//             drives the SRAM port and latches the first failing address.
//             BIST_DATA_WD must be a multiple of 8.
//  Revision : 1.0  initial release
// ============================================================================
module mbist_seq_gen #(
  parameter int                       BIST_ADDR_WD    = 9,
  parameter int                       BIST_DATA_WD    = 32,
  parameter logic [BIST_ADDR_WD-1:0]  BIST_ADDR_START = 9'h000,
  parameter logic [BIST_ADDR_WD-1:0]  BIST_ADDR_END   = 9'h1F8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bist_run,
  input  logic                     cmd_phase,
  input  logic                     cmp_phase,
  input  logic                     run_op,
  input  logic                     run_addr,
  input  logic                     run_sti,
  input  logic                     run_pat,
  input  logic [BIST_DATA_WD-1:0]  mem_rdata,
  output logic                     last_op,
  output logic                     last_addr,
  output logic                     last_sti,
  output logic                     last_pat,
  output logic                     op_reverse,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [BIST_ADDR_WD-1:0]  mem_addr,
  output logic [BIST_DATA_WD-1:0]  mem_wdata,
  output logic                     bist_error,
  output logic [BIST_ADDR_WD-1:0]  err_addr
);

  localparam int         c_NUM_BYTES = BIST_DATA_WD / 8;
  localparam logic [2:0] c_STI_LAST  = 3'd5;
  localparam logic [1:0] c_PAT_LAST  = 2'd3;

  logic [BIST_ADDR_WD-1:0] r_addr;
  logic                    r_op_idx;
  logic [2:0]              r_sti_idx;
  logic [1:0]              r_pat_idx;
  logic                    r_bist_error;
  logic [BIST_ADDR_WD-1:0] r_err_addr;

  logic                    w_dir_up;     // current element walks upward
  logic                    w_nxt_up;     // following element walks upward
  logic                    w_two_ops;    // element has two ops (r,w)
  logic                    w_is_wr;      // current op is a write
  logic                    w_inv;        // current op uses ~background
  logic [7:0]              w_bg_byte;
  logic [BIST_DATA_WD-1:0] w_bg;
  logic [BIST_DATA_WD-1:0] w_op_data;
  logic                    w_mismatch;

  // Decode the fixed March C- element table for the current element/op
  always_comb begin
    w_dir_up  = 1'b1;
    w_nxt_up  = 1'b1;
    w_two_ops = 1'b1;
    w_is_wr   = 1'b0;
    w_inv     = 1'b0;
    case (r_sti_idx)
      3'd0: begin            // up (w0)
        w_two_ops = 1'b0;
        w_is_wr   = 1'b1;
      end
      3'd1: begin            // up (r0, w1)
        w_is_wr = r_op_idx;
        w_inv   = r_op_idx;
      end
      3'd2: begin            // up (r1, w0), next element goes down
        w_is_wr  = r_op_idx;
        w_inv    = ~r_op_idx;
        w_nxt_up = 1'b0;
      end
      3'd3: begin            // down (r0, w1)
        w_dir_up = 1'b0;
        w_nxt_up = 1'b0;
        w_is_wr  = r_op_idx;
        w_inv    = r_op_idx;
      end
      3'd4: begin            // down (r1, w0), next element goes up
        w_dir_up = 1'b0;
        w_is_wr  = r_op_idx;
        w_inv    = ~r_op_idx;
      end
      3'd5: begin            // up (r0)
        w_two_ops = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Select the data background byte for the current pattern
  always_comb begin
    w_bg_byte = 8'h00;
    case (r_pat_idx)
      2'd0:    w_bg_byte = 8'h00;
      2'd1:    w_bg_byte = 8'h55;
      2'd2:    w_bg_byte = 8'h33;
      default: w_bg_byte = 8'h0F;
    endcase
  end

  assign w_bg      = {c_NUM_BYTES{w_bg_byte}};
  assign w_op_data = w_inv ? ~w_bg : w_bg;

  // Terminal-count and direction status for the control FSM
  assign last_op    = w_two_ops ? r_op_idx : ~r_op_idx;
  assign last_addr  = w_dir_up ? (r_addr == BIST_ADDR_END) : (r_addr == BIST_ADDR_START);
  assign last_sti   = (r_sti_idx == c_STI_LAST);
  assign last_pat   = (r_pat_idx == c_PAT_LAST);
  assign op_reverse = (w_dir_up != w_nxt_up);

  // SRAM drive follows the current position directly
  assign mem_req   = cmd_phase;
  assign mem_we    = cmd_phase & w_is_wr;
  assign mem_addr  = r_addr;
  assign mem_wdata = w_op_data;

  assign w_mismatch = cmp_phase & ~w_is_wr & (mem_rdata != w_op_data);

  // Sequence position; a reversal (run_sti without run_addr) keeps the address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= BIST_ADDR_START;
      r_op_idx  <= 1'b0;
      r_sti_idx <= 3'd0;
      r_pat_idx <= 2'd0;
    end else if (!bist_run) begin
      r_addr    <= BIST_ADDR_START;
      r_op_idx  <= 1'b0;
      r_sti_idx <= 3'd0;
      r_pat_idx <= 2'd0;
    end else begin
      if (run_op) begin
        r_op_idx <= last_op ? 1'b0 : (r_op_idx + 1'b1);
      end
      if (run_addr) begin
        if (last_addr) begin
          r_addr <= w_nxt_up ? BIST_ADDR_START : BIST_ADDR_END;
        end else if (w_dir_up) begin
          r_addr <= r_addr + 1'b1;
        end else begin
          r_addr <= r_addr - 1'b1;
        end
      end
      if (run_sti) begin
        r_sti_idx <= last_sti ? 3'd0 : (r_sti_idx + 3'd1);
      end
      if (run_pat) begin
        r_pat_idx <= last_pat ? 2'd0 : (r_pat_idx + 2'd1);
      end
    end
  end

  // Sticky error flag with first-failing-address capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bist_error <= 1'b0;
      r_err_addr   <= '0;
    end else if (!bist_run) begin
      r_bist_error <= 1'b0;
      r_err_addr   <= '0;
    end else if (w_mismatch) begin
      r_bist_error <= 1'b1;
      if (!r_bist_error) begin
        r_err_addr <= r_addr;
      end
    end
  end

  assign bist_error = r_bist_error;
  assign err_addr   = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_mbist_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mbist_seq_gen
//  Purpose  : Directed self-checking bench for mbist_seq_gen: a March C-
//             driver with a 1-cycle SRAM model and an expected-op scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mbist_seq_gen;

  localparam int              AW = 3;
  localparam int              DW = 32;
  localparam int              N  = 4;
  localparam logic [AW-1:0]   A_START = 3'd0;
  localparam logic [AW-1:0]   A_END   = 3'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bist_run = 1'b0;
  logic          cmd_phase = 1'b0;
  logic          cmp_phase = 1'b0;
  logic          run_op = 1'b0;
  logic          run_addr = 1'b0;
  logic          run_sti = 1'b0;
  logic          run_pat = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          last_op, last_addr, last_sti, last_pat, op_reverse;
  logic          mem_req, mem_we, bist_error;
  logic [AW-1:0] mem_addr, err_addr;
  logic [DW-1:0] mem_wdata;

  always #5 clk = ~clk;

  mbist_seq_gen #(
    .BIST_ADDR_WD    (AW),
    .BIST_DATA_WD    (DW),
    .BIST_ADDR_START (A_START),
    .BIST_ADDR_END   (A_END)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bist_run   (bist_run),
    .cmd_phase  (cmd_phase),
    .cmp_phase  (cmp_phase),
    .run_op     (run_op),
    .run_addr   (run_addr),
    .run_sti    (run_sti),
    .run_pat    (run_pat),
    .mem_rdata  (mem_rdata),
    .last_op    (last_op),
    .last_addr  (last_addr),
    .last_sti   (last_sti),
    .last_pat   (last_pat),
    .op_reverse (op_reverse),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .bist_error (bist_error),
    .err_addr   (err_addr)
  );

  // expected SRAM-side view of one op plus {last_op,last_addr,last_sti,last_pat,op_reverse}
  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [4:0]    flags;
  } exp_t;

  exp_t          sb_q[$];
  int            n_err = 0;
  int            n_chk = 0;
  int            req_pulses = 0;
  logic [DW-1:0] sram [0:(1<<AW)-1];

  // March C- reference table: direction, op count, write flag, inverted-data flag
  bit   s_up[6]      = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  int   s_nops[6]    = '{1, 2, 2, 2, 2, 1};
  bit   s_wr[6][2]   = '{'{1'b1,1'b0}, '{1'b0,1'b1}, '{1'b0,1'b1}, '{1'b0,1'b1}, '{1'b0,1'b1}, '{1'b0,1'b0}};
  bit   s_val[6][2]  = '{'{1'b0,1'b0}, '{1'b0,1'b1}, '{1'b1,1'b0}, '{1'b0,1'b1}, '{1'b1,1'b0}, '{1'b0,1'b0}};
  logic [7:0] bgs[4] = '{8'h00, 8'h55, 8'h33, 8'h0F};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One FSM op: cmd cycle, then cmp cycle carrying read data and strobes
  task automatic do_op(input exp_t e, input bit fault,
                       input bit s_op, input bit s_addr, input bit s_sti, input bit s_pat);
    exp_t          got;
    exp_t          want;
    logic [AW-1:0] ra;
    sb_q.push_back(e);
    @(posedge clk); #1;
    cmd_phase = 1'b1;
    cmp_phase = 1'b0;
    {run_op, run_addr, run_sti, run_pat} = 4'b0000;
    @(negedge clk);
    got  = '{mem_req, mem_we, mem_addr, mem_wdata,
             {last_op, last_addr, last_sti, last_pat, op_reverse}};
    want = sb_q.pop_front();
    check("op", got, want);
    if (mem_req) req_pulses++;
    if (mem_we) sram[mem_addr] = mem_wdata;
    ra = mem_addr;
    @(posedge clk); #1;
    cmd_phase = 1'b0;
    cmp_phase = 1'b1;
    mem_rdata = sram[ra] | ((fault && ra == 3'd2) ? 32'h1 : 32'h0);
    run_op = s_op; run_addr = s_addr; run_sti = s_sti; run_pat = s_pat;
    @(posedge clk); #1;
    cmp_phase = 1'b0;
    {run_op, run_addr, run_sti, run_pat} = 4'b0000;
    mem_rdata = '0;
  endtask

  // Walk the full algorithm; stop early on max_ops or when the DUT flags an error
  task automatic run_march(input int max_ops, input bit fault, output int done, output int err_at);
    int   g;
    bit   stop;
    int   a;
    bit   lo, la, rev, fin;
    exp_t e;
    logic [DW-1:0] bg;
    g = 0;
    stop = 1'b0;
    err_at = -1;
    for (int p = 0; p < 4 && !stop; p++) begin
      bg = {4{bgs[p]}};
      for (int s = 0; s < 6 && !stop; s++) begin
        for (int k = 0; k < N && !stop; k++) begin
          a = s_up[s] ? (int'(A_START) + k) : (int'(A_END) - k);
          for (int o = 0; o < s_nops[s] && !stop; o++) begin
            lo  = (o == s_nops[s] - 1);
            la  = (k == N - 1);
            rev = (s_up[s] != s_up[(s + 1) % 6]);
            fin = lo && la && (s == 5) && (p == 3);
            e.req   = 1'b1;
            e.we    = s_wr[s][o];
            e.addr  = a[AW-1:0];
            e.data  = s_val[s][o] ? ~bg : bg;
            e.flags = {lo, la, (s == 5), (p == 3), rev};
            do_op(e, fault, !fin, lo && !(la && rev) && !fin,
                  lo && la && !fin, lo && la && (s == 5) && !fin);
            g++;
            if (bist_error) begin
              err_at = g - 1;
              stop = 1'b1;
            end
            if (g == max_ops) stop = 1'b1;
          end
        end
      end
    end
    done = g;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int done;
    int err_at;

    // Reset values while rst_n is held low
    #12;
    check("reset_flags", {last_op, last_addr, last_sti, last_pat, op_reverse, mem_req, mem_we, bist_error}, 8'b1000_0000);
    check("reset_addr", mem_addr, A_START);
    check("reset_err_addr", err_addr, 3'd0);

    @(negedge clk);
    rst_n = 1'b1;
    bist_run = 1'b1;

    // Full clean run: 4 patterns x 10N ops, including reversals and coincident strobes
    req_pulses = 0;
    run_march(100000, 1'b0, done, err_at);
    check("full_ops", done, 160);
    check("full_req_pulses", req_pulses, 160);
    check("full_err_at", err_at, -1);
    check("full_bist_error", bist_error, 1'b0);
    check("full_end_flags", {last_op, last_addr, last_sti, last_pat}, 4'hF);

    // Clear, then run with bit 0 stuck-at-1 at address 2
    bist_run = 1'b0;
    @(posedge clk); #1;
    bist_run = 1'b1;
    run_march(100000, 1'b1, done, err_at);
    check("fault_err_at", err_at, 8);
    check("fault_bist_error", bist_error, 1'b1);
    check("fault_err_addr", err_addr, 3'd2);

    // Dropping bist_run clears the error state
    bist_run = 1'b0;
    @(posedge clk); #1;
    check("clear_bist_error", bist_error, 1'b0);
    check("clear_err_addr", err_addr, 3'd0);
    check("clear_addr", mem_addr, A_START);

    // Abort in the middle of S3 of pattern 1, then restart from the top
    bist_run = 1'b1;
    run_march(62, 1'b0, done, err_at);
    check("abort_ops", done, 62);
    check("abort_addr", mem_addr, 3'd2);
    bist_run = 1'b0;
    @(posedge clk); #1;
    bist_run = 1'b1;
    run_march(7, 1'b0, done, err_at);
    check("rerun_ops", done, 7);
    check("rerun_addr", mem_addr, 3'd1);

    // Asynchronous reset mid-cycle takes effect immediately
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_flags", {last_op, last_addr, last_sti, last_pat, op_reverse, mem_req, mem_we, bist_error}, 8'b1000_0000);
    check("async_reset_addr", mem_addr, A_START);
    #10;
    rst_n = 1'b1;
    #10;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
